rega_multizona: RTL
===================

REGA_MULTIZONA -- requirements
Module: rega_multizona

Interface
REQ-001 SHALL expose parameter N_ZONES, default 4, number of irrigation zones (2..8).
REQ-002 SHALL expose parameter TIME_W, default 8, width of the tick countdown timer.
REQ-003 SHALL expose parameter PRESC, default 50000000, number of Clk cycles per tick (>=2).
REQ-004 SHALL expose parameters DRIP_T=30, SPRAY_T=15, MIX_T=10, CLEAN_T=20, each a tick count (1..2^TIME_W-1).
REQ-005 SHALL have port Clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port Rst  in  1  reset; synchronous, active-low.
REQ-007 SHALL have port Us  in  N_ZONES  soil sensor per zone; 1 = dry.
REQ-008 SHALL have port Mode  in  N_ZONES  method per zone; 1 = spray (Asp), 0 = drip (Got).
REQ-009 SHALL have port Nivel  in  2  tank level: 00 empty, 01 low, 10 mid, 11 full.
REQ-010 SHALL have port Adub  in  1  fertilizer request, level-sensitive, active-high.
REQ-011 SHALL have port Valve  out  N_ZONES  one-hot zone valve, all-zero when not irrigating.
REQ-012 SHALL have ports Asp, Got, Ve, Mist, Limp  out  1 each: spray on, drip on, tank inlet valve, mixer on, cleaning on.
REQ-013 SHALL have ports Zone  out  3  active/last zone index; Remain  out  TIME_W  ticks left in current timed state; Estado  out  3  FSM state code.

Function
REQ-014 SHALL generate an internal one-cycle tick every PRESC Clk cycles from a free-running prescaler; all timers decrement only on tick.
REQ-015 SHALL implement FSM states IDLE=0, SCAN=1, IRRIGA=2, MIX=3, LIMP=4; Estado reflects current state.
REQ-016 IDLE: if Adub=1 and Nivel!=00 go to MIX with Remain=MIX_T; else if any Us bit=1 and Nivel!=00 go to SCAN; Adub has priority over irrigation.
REQ-017 SCAN: round-robin search starting at (last Zone+1) mod N_ZONES, one candidate per Clk; first zone with Us=1 becomes Zone, load Remain=SPRAY_T if Mode[Zone]=1 else DRIP_T, go to IRRIGA; if N_ZONES candidates checked with none dry, return to IDLE.
REQ-018 IRRIGA: Valve[Zone]=1; Asp=Mode[Zone], Got=~Mode[Zone]; Remain decrements per tick, no wrap below 0.
REQ-019 IRRIGA SHALL exit to IDLE on the first of: Remain reaching 0 on a tick, Us[Zone] going 0, Nivel=00; outputs drop in the cycle state becomes IDLE.
REQ-020 MIX: Mist=1, Valve/Asp/Got=0; on Remain reaching 0 go to LIMP with Remain=CLEAN_T.
REQ-021 LIMP: Limp=1, Mist=0, irrigation outputs forced 0; no irrigation or new Adub accepted until LIMP ends; on Remain 0 go to IDLE.
REQ-022 Adub asserted during IRRIGA SHALL be honoured only after IRRIGA ends (IDLE priority rule); Adub deasserted in MIX/LIMP SHALL NOT abort the sequence.
REQ-023 Ve SHALL be 1 exactly when Nivel!=11 and state is not MIX or LIMP; Ve is combinational from Nivel and state.
REQ-024 Nivel=00 in MIX SHALL abort to LIMP immediately with Remain=CLEAN_T.
REQ-025 At most one Valve bit SHALL ever be 1, and never simultaneously with Mist or Limp.
REQ-026 Remain SHALL hold 0 in IDLE and SCAN.

Reset
REQ-027 With Rst=0 at a rising Clk edge: state IDLE, Zone=N_ZONES-1 (so first scan starts at zone 0), Remain=0, prescaler=0, Valve=0, Asp=Got=Mist=Limp=0.
REQ-028 Reset asserted mid-operation (any state) SHALL take effect on the next edge with the values of REQ-027; no output glitch beyond that edge.

Verification (PRESC=4, N_ZONES=4, DRIP_T=3, SPRAY_T=2, MIX_T=2, CLEAN_T=3)
REQ-029 Reset, Us=0010, Mode=0000, Nivel=11 -> Zone=1, Valve=0010, Got=1 for 3 ticks (12 Clk), then Valve=0000, Estado=0.
REQ-030 Us=1111 held, Mode=0101 -> zones served 0,1,2,3,0 in order; Asp=1 on zones 0,2, Got=1 on 1,3.
REQ-031 Zone 2 irrigating, Us[2] drops to 0 after 1 tick -> Valve=0000 next cycle, Remain=0, Estado=0.
REQ-032 Adub=1 and Us=1111 together from IDLE -> MIX 2 ticks (Mist=1, Ve=0), LIMP 3 ticks (Limp=1), no Valve bit set during either.
REQ-033 Nivel=00 during IRRIGA -> Valve=0 next cycle; Nivel=00 during MIX -> LIMP next cycle; Nivel=10 in IDLE -> Ve=1.
REQ-034 Rst=0 for one edge while in LIMP with Remain=2 -> all outputs 0, Estado=0, Remain=0 after that edge.

Source files
------------

// File: rtl/rega_multizona.sv
// Multi-zone irrigation controller: round-robin zone scan, per-zone drip/spray
// timing, fertilizer mix followed by cleaning, and tank inlet control.
module rega_multizona #(
  parameter int N_ZONES = 4,
  parameter int TIME_W  = 8,
  parameter int PRESC   = 50000000,
  parameter int DRIP_T  = 30,
  parameter int SPRAY_T = 15,
  parameter int MIX_T   = 10,
  parameter int CLEAN_T = 20
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [N_ZONES-1:0] Us,
  input  logic [N_ZONES-1:0] Mode,
  input  logic [1:0]         Nivel,
  input  logic               Adub,
  output logic [N_ZONES-1:0] Valve,
  output logic               Asp,
  output logic               Got,
  output logic               Ve,
  output logic               Mist,
  output logic               Limp,
  output logic [2:0]         Zone,
  output logic [TIME_W-1:0]  Remain,
  output logic [2:0]         Estado
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    IRRIGA = 3'd2,
    MIX    = 3'd3,
    LIMP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [2:0]          zone_q, zone_d;
  logic [2:0]          cand_q, cand_d;
  logic [2:0]          scnt_q, scnt_d;
  logic [TIME_W-1:0]   remain_q, remain_d;

  logic tick;
  logic us_zone, mode_zone, us_cand, mode_cand;
  logic remain_last, tank_empty;
  logic [2:0] cand_next, scan_start;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      zone_q   <= 3'(N_ZONES - 1);
      cand_q   <= '0;
      scnt_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      zone_q   <= zone_d;
      cand_q   <= cand_d;
      scnt_q   <= scnt_d;
      remain_q <= remain_d;
    end
  end

  // Zone-indexed sensor/mode selection, written as a loop so the 3-bit
  // index never over-addresses a narrower vector.
  always_comb begin
    us_zone   = 1'b0;
    mode_zone = 1'b0;
    us_cand   = 1'b0;
    mode_cand = 1'b0;
    for (int unsigned i = 0; i < N_ZONES; i++) begin
      if (zone_q == 3'(i)) begin
        us_zone   = Us[i];
        mode_zone = Mode[i];
      end
      if (cand_q == 3'(i)) begin
        us_cand   = Us[i];
        mode_cand = Mode[i];
      end
    end
  end

  always_comb begin
    tick        = (pre_q == PW'(PRESC - 1));
    pre_d       = tick ? '0 : pre_q + 1'b1;
    remain_last = (remain_q <= TIME_W'(1));
    tank_empty  = (Nivel == 2'b00);
    cand_next   = (cand_q == 3'(N_ZONES - 1)) ? 3'd0 : cand_q + 3'd1;
    scan_start  = (zone_q == 3'(N_ZONES - 1)) ? 3'd0 : zone_q + 3'd1;

    state_d  = state_q;
    zone_d   = zone_q;
    cand_d   = cand_q;
    scnt_d   = scnt_q;
    remain_d = remain_q;

    unique case (state_q)
      IDLE: begin
        remain_d = '0;
        if (Adub && !tank_empty) begin
          state_d  = MIX;
          remain_d = TIME_W'(MIX_T);
        end else if ((|Us) && !tank_empty) begin
          state_d = SCAN;
          cand_d  = scan_start;
          scnt_d  = '0;
        end
      end
      SCAN: begin
        remain_d = '0;
        if (us_cand) begin
          state_d  = IRRIGA;
          zone_d   = cand_q;
          remain_d = mode_cand ? TIME_W'(SPRAY_T) : TIME_W'(DRIP_T);
        end else if (scnt_q == 3'(N_ZONES - 1)) begin
          state_d = IDLE;
        end else begin
          cand_d = cand_next;
          scnt_d = scnt_q + 3'd1;
        end
      end
      IRRIGA: begin
        if (tank_empty || !us_zone || (tick && remain_last)) begin
          state_d  = IDLE;
          remain_d = '0;
        end else if (tick) begin
          remain_d = remain_q - 1'b1;
        end
      end
      MIX: begin
        if (tank_empty || (tick && remain_last)) begin
          state_d  = LIMP;
          remain_d = TIME_W'(CLEAN_T);
        end else if (tick) begin
          remain_d = remain_q - 1'b1;
        end
      end
      LIMP: begin
        if (tick && remain_last) begin
          state_d  = IDLE;
          remain_d = '0;
        end else if (tick) begin
          remain_d = remain_q - 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        remain_d = '0;
      end
    endcase
  end

  // Outputs decode from current state only, so they drop in the same cycle
  // the state leaves IRRIGA/MIX/LIMP.
  always_comb begin
    Valve = '0;
    for (int unsigned i = 0; i < N_ZONES; i++) begin
      Valve[i] = (state_q == IRRIGA) && (zone_q == 3'(i));
    end
    Asp    = (state_q == IRRIGA) && mode_zone;
    Got    = (state_q == IRRIGA) && !mode_zone;
    Mist   = (state_q == MIX);
    Limp   = (state_q == LIMP);
    Ve     = (Nivel != 2'b11) && (state_q != MIX) && (state_q != LIMP);
    Zone   = zone_q;
    Remain = remain_q;
    Estado = state_q;
  end

endmodule
